// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Parametrised pipeline stage register carrying a control bundle and a data
//   bundle between two adjacent pipeline stages. The stage has a valid/ready
//   handshake, flush with bubble insertion, synchronous active-low reset and a
//   saturating stall-cycle counter.
//
//   Optional feature macro: PIPE_SKID_EN
//     defined   : one-entry skid register; in_ready_o is a pure register output
//     undefined : in_ready_o = !out_valid_o || out_ready_i (combinational)
//
// Ports
//   clk_i        clock, all state updates on posedge
//   rst_i        synchronous reset, active-low
//   flush_i      discard stage contents and insert a bubble
//   in_valid_i   upstream holds a valid instruction
//   in_ready_o   stage accepts input this cycle
//   in_ctrl_i    upstream control bundle   [CTRL_W]
//   in_data_i    upstream data bundle      [DATA_W]
//   out_valid_o  stage holds a valid instruction
//   out_ready_i  downstream consumes this cycle
//   out_ctrl_o   registered control bundle [CTRL_W], zero whenever invalid
//   out_data_o   registered data bundle    [DATA_W], not cleared on bubble
//   stall_cnt_o  saturating count of back-pressure cycles [CNT_W]
module pipe_stage_reg #(
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned DATA_W = 128,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic              valid;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;
   logic [CNT_W-1:0]  stall_cnt;
   logic              in_fire;
   logic              out_fire;
   logic              stall;

`ifdef PIPE_SKID_EN
   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   assign in_ready_o = !skid_valid;
`else
   assign in_ready_o = !valid || out_ready_i;
`endif

   assign in_fire  = in_valid_i && in_ready_o;
   assign out_fire = valid && out_ready_i;
   assign stall    = valid && !out_ready_i && !flush_i;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid     <= 1'b0;
         ctrl      <= '0;
         data      <= '0;
         stall_cnt <= '0;
`ifdef PIPE_SKID_EN
         skid_valid <= 1'b0;
         skid_ctrl  <= '0;
         skid_data  <= '0;
`endif
      end else begin
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;

         if (flush_i) begin
            // Bubble: valid and ctrl cleared together, data left as is.
            valid <= 1'b0;
            ctrl  <= '0;
`ifdef PIPE_SKID_EN
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
`endif
         end
`ifdef PIPE_SKID_EN
         // A full skid implies a full main entry; refill main from skid as it drains.
         else if (skid_valid) begin
            if (out_ready_i) begin
               valid      <= 1'b1;
               ctrl       <= skid_ctrl;
               data       <= skid_data;
               skid_valid <= 1'b0;
               skid_ctrl  <= '0;
            end
         end else if (in_fire) begin
            if (!valid || out_ready_i) begin
               valid <= 1'b1;
               ctrl  <= in_ctrl_i;
               data  <= in_data_i;
            end else begin
               skid_valid <= 1'b1;
               skid_ctrl  <= in_ctrl_i;
               skid_data  <= in_data_i;
            end
         end else if (out_fire) begin
            valid <= 1'b0;
            ctrl  <= '0;
         end
`else
         else if (in_fire) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl_i;
            data  <= in_data_i;
         end else if (out_fire) begin
            valid <= 1'b0;
            ctrl  <= '0;
         end
`endif
      end
   end

   assign out_valid_o = valid;
   assign out_ctrl_o  = ctrl;
   assign out_data_o  = data;
   assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed self-checking bench for pipe_stage_reg (CNT_W overridden to 4 so
//   counter saturation is reachable). Inputs change 1 time unit after the
//   rising edge; outputs are checked at that point, after state has settled.
module tb_pipe_stage_reg;

   localparam int unsigned CTRL_W = 8;
   localparam int unsigned DATA_W = 128;
   localparam int unsigned CNT_W  = 4;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              flush_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [CTRL_W-1:0] in_ctrl_i;
   logic [DATA_W-1:0] in_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [CTRL_W-1:0] out_ctrl_o;
   logic [DATA_W-1:0] out_data_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk_i = ~clk_i;

   pipe_stage_reg #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_ctrl_i  (in_ctrl_i),
      .in_data_i  (in_data_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_ctrl_o (out_ctrl_o),
      .out_data_o (out_data_o),
      .stall_cnt_o(stall_cnt_o)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                            input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] s);
      chk({tag, ".valid"}, DATA_W'(out_valid_o), DATA_W'(v));
      chk({tag, ".ctrl"},  DATA_W'(out_ctrl_o),  DATA_W'(c));
      chk({tag, ".data"},  out_data_o,           d);
      chk({tag, ".cnt"},   DATA_W'(stall_cnt_o), DATA_W'(s));
   endtask

   initial begin
      rst_i       = 1'b0;
      flush_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_ctrl_i   = '0;
      in_data_i   = '0;
      out_ready_i = 1'b0;

      // Reset from power-up
      step();
      chk_state("reset0", 1'b0, 8'h00, '0, 4'd0);
      chk("reset0.in_ready", DATA_W'(in_ready_o), DATA_W'(1'b1));

      // Reset mid-stream
      rst_i      = 1'b1;
      in_valid_i = 1'b1;
      in_ctrl_i  = 8'hA5;
      in_data_i  = 128'h1234;
      step();
      chk_state("load_a5", 1'b1, 8'hA5, 128'h1234, 4'd0);
      in_valid_i = 1'b0;
      rst_i      = 1'b0;
      step();
      chk_state("reset_mid", 1'b0, 8'h00, '0, 4'd0);
      rst_i = 1'b1;

      // Streaming 1..10 back-to-back
      out_ready_i = 1'b1;
      in_valid_i  = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_ctrl_i = CTRL_W'(i);
         in_data_i = DATA_W'(i * 256);
         step();
         chk_state($sformatf("stream%0d", i), 1'b1, CTRL_W'(i), DATA_W'(i * 256), 4'd0);
      end
      in_valid_i = 1'b0;
      step();
      chk_state("stream_drain", 1'b0, 8'h00, 128'hA00, 4'd0);

      // Back-pressure on ctrl=0x3C
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_ctrl_i   = 8'h3C;
      in_data_i   = 128'hBEEF;
      step();
      chk_state("bp_load", 1'b1, 8'h3C, 128'hBEEF, 4'd0);
      in_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk_state("bp_hold", 1'b1, 8'h3C, 128'hBEEF, 4'd5);
`ifdef PIPE_SKID_EN
      chk("bp_hold.in_ready", DATA_W'(in_ready_o), DATA_W'(1'b1));
`else
      chk("bp_hold.in_ready", DATA_W'(in_ready_o), DATA_W'(1'b0));
      out_ready_i = 1'b1;
      #1;
      chk("bp_comb.in_ready", DATA_W'(in_ready_o), DATA_W'(1'b1));
`endif
      out_ready_i = 1'b1;
      step();
      chk_state("bp_release", 1'b0, 8'h00, 128'hBEEF, 4'd5);
      step();
      chk("bp_once.valid", DATA_W'(out_valid_o), DATA_W'(1'b0));

      // Flush vs load
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_ctrl_i   = 8'h11;
      in_data_i   = 128'hD00D;
      step();
      chk_state("fl_load", 1'b1, 8'h11, 128'hD00D, 4'd5);
      flush_i   = 1'b1;
      in_ctrl_i = 8'hFF;
      in_data_i = 128'hFFFF;
      step();
      chk_state("flush", 1'b0, 8'h00, 128'hD00D, 4'd5);
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      step();
      chk_state("flush_drop", 1'b0, 8'h00, 128'hD00D, 4'd5);

      // Counter saturation: 5 + 20 stalled cycles clamps at 15
      in_valid_i = 1'b1;
      in_ctrl_i  = 8'h42;
      in_data_i  = 128'h4242;
      step();
      in_valid_i = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk_state("sat", 1'b1, 8'h42, 128'h4242, 4'd15);
      step();
      chk("sat_hold.cnt", DATA_W'(stall_cnt_o), DATA_W'(4'd15));

      // Drain
      out_ready_i = 1'b1;
      step();
      chk_state("sat_drain", 1'b0, 8'h00, 128'h4242, 4'd15);

`ifdef PIPE_SKID_EN
      // Skid: main holds 1, ctrl=2 offered under back-pressure lands in skid
      out_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      in_ctrl_i   = 8'h01;
      in_data_i   = 128'h1;
      step();
      chk_state("skid_main", 1'b1, 8'h01, 128'h1, 4'd15);
      chk("skid_main.in_ready", DATA_W'(in_ready_o), DATA_W'(1'b1));
      in_ctrl_i = 8'h02;
      in_data_i = 128'h2;
      step();
      chk_state("skid_full", 1'b1, 8'h01, 128'h1, 4'd15);
      chk("skid_full.in_ready", DATA_W'(in_ready_o), DATA_W'(1'b0));
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      step();
      chk_state("skid_move", 1'b1, 8'h02, 128'h2, 4'd15);
      chk("skid_move.in_ready", DATA_W'(in_ready_o), DATA_W'(1'b1));
      step();
      chk_state("skid_drain", 1'b0, 8'h00, 128'h2, 4'd15);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; successor to the fixed-field ID/EX latch.
- Carries a control bundle and a data bundle between any two adjacent pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, flush with bubble insertion, synchronous reset and a saturating stall-cycle counter.
- Optional skid entry registers the upstream ready path.

Parameters:
- CTRL_W, 8, width of the control bundle (WB/M/EX fields concatenated). Zeroed on bubble.
- DATA_W, 128, width of the data bundle (operands, immediate, register indices). Not cleared on bubble.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset, synchronous, active-low.
- flush_i  in  1  discard stage contents and insert a bubble.
- in_valid_i  in  1  upstream holds a valid instruction.
- in_ready_o  out  1  stage accepts input this cycle.
- in_ctrl_i  in  CTRL_W  upstream control bundle.
- in_data_i  in  DATA_W  upstream data bundle.
- out_valid_o  out  1  stage holds a valid instruction.
- out_ready_i  in  1  downstream consumes this cycle.
- out_ctrl_o  out  CTRL_W  registered control bundle.
- out_data_o  out  DATA_W  registered data bundle.
- stall_cnt_o  out  CNT_W  saturating count of back-pressure cycles.

Behaviour:
- Reset (rst_i==0 at posedge):
  - out_valid_o=0, out_ctrl_o=0, out_data_o=0, stall_cnt_o=0.
  - Skid entry (if present) emptied.
  - Reset overrides flush and load.
- Handshake:
  - Transfer in when in_valid_i && in_ready_o.
  - Transfer out when out_valid_o && out_ready_i.
  - Latency in to out is 1 cycle.
  - No beat is lost or duplicated. Order is preserved.
- Base mode (macro off):
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - On accept: out_ctrl_o<=in_ctrl_i, out_data_o<=in_data_i, out_valid_o<=1.
  - Out transfer without accept: out_valid_o<=0, out_ctrl_o<=0.
  - Neither transfer: all outputs hold (stall).
  - Simultaneous in and out transfer: new beat replaces the old one, out_valid_o stays 1.
- Flush (flush_i==1, rst_i==1):
  - out_valid_o<=0, out_ctrl_o<=0, out_data_o holds.
  - Any input offered that cycle is dropped, even if in_ready_o is high. Upstream must treat it as killed.
  - Skid entry also cleared.
  - Flush has priority over load and stall.
- Bubble invariant: out_valid_o==0 implies out_ctrl_o==0, so downstream write-enables are inert without checking valid.
- Stall counter:
  - +1 on each cycle with out_valid_o && !out_ready_i && !flush_i.
  - Saturates at 2^CNT_W-1. Cleared only by reset.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined:
  - Adds a one-entry skid register (ctrl, data, valid).
  - in_ready_o = !skid_valid, a pure register output with no combinational path from out_ready_i.
  - Accept while main is full and !out_ready_i: beat goes to skid.
  - Accept while main is full and out_ready_i==1: main takes the new beat.
  - Main drained and skid valid: skid moves to main on the same edge, skid cleared.
  - Reset value of skid_valid is 0.
- Undefined: no skid storage; combinational in_ready_o as in base mode.

Test Plan:
- Reset mid-stream:
  - Stimulus: load ctrl=0xA5, data=0x1234, then rst_i=0 for 1 cycle.
  - Response: out_valid_o=0, out_ctrl_o=0, out_data_o=0, stall_cnt_o=0 next cycle.
- Streaming:
  - Stimulus: out_ready_i=1, in_valid_i=1, ctrl 1..10 back-to-back.
  - Response: out_ctrl_o 1..10 one cycle later with no gaps; stall_cnt_o stays 0.
- Back-pressure:
  - Stimulus: hold beat ctrl=0x3C, drop out_ready_i for 5 cycles.
  - Response: out_ctrl_o stays 0x3C, in_ready_o=0 (base), stall_cnt_o=5.
  - Release: out_ready_i=1 transfers the beat once.
- Flush vs load:
  - Stimulus: flush_i=1 with in_valid_i=1, ctrl=0xFF.
  - Response: out_valid_o=0, out_ctrl_o=0, out_data_o unchanged, beat dropped.
- Counter saturation:
  - Stimulus: CNT_W=4, stall 20 cycles.
  - Response: stall_cnt_o=15 and holds.
- Skid (PIPE_SKID_EN):
  - Stimulus: main full (ctrl=1), out_ready_i=0, offer ctrl=2.
  - Response: in_ready_o=1 then 0; ctrl=2 stored in skid.
  - Then out_ready_i=1: output 1 then 2, in_ready_o back to 1.
